// File: rtl/neuron_array_core.sv
// Time-multiplexed array of two-variable (v, w) fixed-point neurons sharing a
// 4-stage update pipeline, with step-control FSM, preload port and spike flag.
module neuron_array_core #(
  parameter int N_NEURONS  = 8,
  parameter int INT_WIDTH  = 3,
  parameter int FRC_WIDTH  = 12,
  parameter int TAU_SHIFT  = 1,
  parameter int TIME_SHIFT = 7,
  parameter int A_CONST    = 2867,
  parameter int DZ_THRESH  = 175,
  parameter int SPIKE_TH   = 4096,
  parameter int V_RST      = -4895,
  parameter int W_RST      = -2560,
  localparam int IDX_W     = $clog2(N_NEURONS),
  localparam int W         = 1 + INT_WIDTH + FRC_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic                    cfg_we,
  input  logic                    cfg_sel,
  input  logic [IDX_W-1:0]        cfg_addr,
  input  logic signed [W-1:0]     cfg_i,
  input  logic signed [W-1:0]     cfg_v,
  input  logic signed [W-1:0]     cfg_w,
  output logic                    out_valid,
  output logic [IDX_W-1:0]        out_idx,
  output logic signed [W-1:0]     out_v,
  output logic signed [W-1:0]     out_w,
  output logic                    spike
);
  localparam int XW = W + 4;
  localparam int YW = W + 2;
  localparam logic signed [YW-1:0] A_Y      = YW'(A_CONST);
  localparam logic signed [XW-1:0] RND_V    = XW'(2 ** (TIME_SHIFT - 1));
  localparam logic signed [XW-1:0] RND_W    = XW'(2 ** (TAU_SHIFT + TIME_SHIFT - 1));
  localparam logic signed [XW-1:0] DZ_POS   = XW'(DZ_THRESH);
  localparam logic signed [XW-1:0] DZ_NEG   = XW'(-DZ_THRESH);
  localparam logic signed [XW-1:0] SPIKE_X  = XW'(SPIKE_TH);
  localparam logic signed [XW-1:0] SAT_MAX  = XW'(2 ** (W - 1) - 1);
  localparam logic signed [XW-1:0] SAT_MIN  = XW'(-(2 ** (W - 1)));
  localparam logic signed [W-1:0]  V_INIT   = W'(V_RST);
  localparam logic signed [W-1:0]  W_INIT   = W'(W_RST);
  localparam logic [IDX_W-1:0]     LAST     = IDX_W'(N_NEURONS - 1);
  localparam logic signed [W:0]    E_MAX    = 3;

  // Piecewise-linear 2^x: (1 + frac) scaled by the integer part; the exponent is
  // clipped at +3 so the result always fits the widened datapath.
  function automatic logic signed [XW-1:0] pow_2_function(input logic signed [W:0] x);
    logic signed [W:0] e;
    logic [XW-1:0]     m;
    logic [XW-1:0]     r;
    e = x >>> FRC_WIDTH;
    m = {{(XW-FRC_WIDTH-1){1'b0}}, 1'b1, x[FRC_WIDTH-1:0]};
    if (e >= E_MAX)   r = m << 3;
    else if (!e[W])   r = m << e[1:0];
    else              r = m >> (-e);
    return $signed(r);
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [XW-1:0] x);
    if (x > SAT_MAX)      return SAT_MAX[W-1:0];
    else if (x < SAT_MIN) return SAT_MIN[W-1:0];
    else                  return x[W-1:0];
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_reg, state_next;
  logic [IDX_W-1:0] cnt_reg, cnt_next;
  logic issue, done_reg;

  logic                    s1_valid, s2_valid, s3_valid;
  logic [IDX_W-1:0]        s1_idx, s2_idx, s3_idx;
  logic signed [W-1:0]     s1_v, s1_w, s1_i, s2_v, s2_w, s3_v_old;
  logic signed [XW-1:0]    s2_p, s2_n, s2_lin, s3_vn, s3_wn;
  logic signed [YW-1:0]    s2_y1;

  logic signed [W-1:0]     v_mem [N_NEURONS];
  logic signed [W-1:0]     w_mem [N_NEURONS];
  logic signed [W-1:0]     i_mem [N_NEURONS];
  logic signed [W-1:0]     sat_v, sat_w;
  logic                    cfg_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= (state_reg == DONE);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    issue      = 1'b0;
    case (state_reg)
      IDLE: if (start) begin
        state_next = RUN;
        cnt_next   = '0;
      end
      RUN: begin
        issue = 1'b1;
        if (cnt_reg == LAST) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + IDX_W'(1);
        end
      end
      // The last neuron's result is written on the edge that leaves DRAIN.
      DRAIN: if (s3_valid && s3_idx == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy   = (state_reg != IDLE);
  assign done   = done_reg;
  assign cfg_ok = cfg_we && (state_reg == IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
      logic signed [W-1:0] v_q, w_q, i_q;
      logic wb_hit, cfg_hit;
      assign wb_hit  = s3_valid && (s3_idx == IDX_W'(gi));
      assign cfg_hit = cfg_ok && (cfg_addr == IDX_W'(gi));
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= V_INIT;
          w_q <= W_INIT;
          i_q <= '0;
        end else begin
          if (wb_hit) begin
            v_q <= sat_v;
            w_q <= sat_w;
          end else if (cfg_hit && cfg_sel) begin
            v_q <= cfg_v;
            w_q <= cfg_w;
          end
          if (cfg_hit && !cfg_sel) i_q <= cfg_i;
        end
      end
      assign v_mem[gi] = v_q;
      assign w_mem[gi] = w_q;
      assign i_mem[gi] = i_q;
    end
  endgenerate

  // Stage 2 inputs: exponentials and the linear part of dv, plus the w drive y1.
  logic signed [W:0]    v1e, v1n;
  logic signed [XW-1:0] v1x, w1x, i1x, p_c, n_c, lin_c;
  logic signed [YW-1:0] v1y, w1y, y1_c;
  assign v1e   = {s1_v[W-1], s1_v};
  assign v1n   = -v1e;
  assign v1x   = {{(XW-W){s1_v[W-1]}}, s1_v};
  assign w1x   = {{(XW-W){s1_w[W-1]}}, s1_w};
  assign i1x   = {{(XW-W){s1_i[W-1]}}, s1_i};
  assign v1y   = {{(YW-W){s1_v[W-1]}}, s1_v};
  assign w1y   = {{(YW-W){s1_w[W-1]}}, s1_w};
  assign p_c   = pow_2_function(v1e);
  assign n_c   = pow_2_function(v1n);
  assign lin_c = (v1x <<< 2) + v1x - w1x + i1x;
  assign y1_c  = v1y + A_Y - (w1y >>> 1);

  // Stage 3 inputs: full dv with dead-zone, rounded timestep integration.
  logic signed [XW-1:0] diff_c, dv_raw_c, dv_c, v2x, w2x, y1x, vn_c, wn_c;
  logic                 in_dz_c;
  assign diff_c   = s2_n - s2_p;
  assign dv_raw_c = (diff_c <<< 1) + diff_c + s2_lin;
  assign in_dz_c  = (dv_raw_c > DZ_NEG) && (dv_raw_c < DZ_POS);
  assign dv_c     = in_dz_c ? '0 : dv_raw_c;
  assign v2x      = {{(XW-W){s2_v[W-1]}}, s2_v};
  assign w2x      = {{(XW-W){s2_w[W-1]}}, s2_w};
  assign y1x      = {{(XW-YW){s2_y1[YW-1]}}, s2_y1};
  assign vn_c     = v2x + ((dv_c + RND_V) >>> TIME_SHIFT);
  assign wn_c     = w2x + ((y1x + RND_W) >>> (TAU_SHIFT + TIME_SHIFT));

  logic signed [XW-1:0] vox, svx;
  logic                 spike_c;
  assign sat_v   = sat(s3_vn);
  assign sat_w   = sat(s3_wn);
  assign vox     = {{(XW-W){s3_v_old[W-1]}}, s3_v_old};
  assign svx     = {{(XW-W){sat_v[W-1]}}, sat_v};
  assign spike_c = s3_valid && (vox < SPIKE_X) && (svx >= SPIKE_X);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_valid <= 1'b0;
      spike     <= 1'b0;
      out_idx   <= '0;
      out_v     <= '0;
      out_w     <= '0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        s1_idx <= cnt_reg;
        s1_v   <= v_mem[cnt_reg];
        s1_w   <= w_mem[cnt_reg];
        s1_i   <= i_mem[cnt_reg];
      end
      s2_valid <= s1_valid;
      s2_idx   <= s1_idx;
      s2_v     <= s1_v;
      s2_w     <= s1_w;
      s2_p     <= p_c;
      s2_n     <= n_c;
      s2_lin   <= lin_c;
      s2_y1    <= y1_c;
      s3_valid <= s2_valid;
      s3_idx   <= s2_idx;
      s3_v_old <= s2_v;
      s3_vn    <= vn_c;
      s3_wn    <= wn_c;
      out_valid <= s3_valid;
      spike     <= spike_c;
      if (s3_valid) begin
        out_idx <= s3_idx;
        out_v   <= sat_v;
        out_w   <= sat_w;
      end
    end
  end
endmodule

// File: tb/tb_neuron_array_core.sv
// Directed bench for neuron_array_core: hand-computed vector table plus a
// bit-accurate integer reference model for multi-step and corner sequences.
module tb_neuron_array_core;
  localparam int N  = 8;
  localparam int W  = 16;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst, start, cfg_we, cfg_sel;
  logic [IW-1:0] cfg_addr;
  logic signed [W-1:0] cfg_i, cfg_v, cfg_w;
  logic busy, done, out_valid, spike;
  logic [IW-1:0] out_idx;
  logic signed [W-1:0] out_v, out_w;

  neuron_array_core #(.N_NEURONS(N), .SPIKE_TH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_i(cfg_i), .cfg_v(cfg_v), .cfg_w(cfg_w),
    .out_valid(out_valid), .out_idx(out_idx), .out_v(out_v), .out_w(out_w),
    .spike(spike)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx; int v; int w; int i;
    int exp_v; int exp_w; int exp_spike;
  } vec_t;

  vec_t tbl[N];
  int checks = 0;
  int errors = 0;
  int step_no = 0;
  int mv[N], mw[N], mi[N];
  int ev[N], ew[N], es[N];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int pw(input int x);
    int f, e, m;
    f = x & 4095;
    e = (x - f) / 4096;
    m = 4096 + f;
    if (e > 3) e = 3;
    if (e >= 0) return m * (2 ** e);
    return m / (2 ** (-e));
  endfunction

  function automatic int clip(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_expect();
    for (int k = 0; k < N; k++) begin
      int dv, y1;
      dv = 3 * (pw(-mv[k]) - pw(mv[k])) + 5 * mv[k] - mw[k] + mi[k];
      if (dv > -175 && dv < 175) dv = 0;
      ev[k] = clip(mv[k] + ((dv + 64) >>> 7));
      y1 = mv[k] + 2867 - (mw[k] >>> 1);
      ew[k] = clip(mw[k] + ((y1 + 128) >>> 8));
      es[k] = (mv[k] < 4 && ev[k] >= 4) ? 1 : 0;
    end
  endtask

  task automatic cfg_write(input int a, input bit sel, input int v, input int w, input int i);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = IW'(a);
    cfg_v = W'(v); cfg_w = W'(w); cfg_i = W'(i);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Caller is at a negedge; start is sampled at edge E and every output is
  // checked on the negedge following E+n for n = 0..N+4.
  task automatic run_step(input bit poke);
    step_no++;
    start = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= N + 4; n++) begin
      @(negedge clk);
      chk("busy", busy, (n <= N + 3) ? 1 : 0);
      chk("done", done, (n == N + 4) ? 1 : 0);
      chk("out_valid", out_valid, (n >= 4 && n <= N + 3) ? 1 : 0);
      if (out_valid && n >= 4 && n <= N + 3) begin
        int k;
        k = n - 4;
        $display("step %0d edge E+%0d idx=%0d v=%0d w=%0d spike=%0b",
                 step_no, n, out_idx, out_v, out_w, spike);
        chk("out_idx", out_idx, k);
        chk("out_v", out_v, ev[k]);
        chk("out_w", out_w, ew[k]);
        chk("spike", spike, es[k]);
      end
      start = 1'b0;
      if (poke && n == 2) begin
        start = 1'b1;
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 3'd0; cfg_v = 16'sd1234; cfg_w = 16'sd1234;
      end
      if (poke && n == 3) begin
        cfg_sel = 1'b0; cfg_addr = 3'd1; cfg_i = 16'sd5000;
      end
      if (poke && n == 4) cfg_we = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      mv[k] = ev[k];
      mw[k] = ew[k];
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = -4895; mw[k] = -2560; mi[k] = 0;
    end
  endtask

  initial begin
    tbl[0] = '{0, -4895, -2560, 0, -4880, -2563, 0};
    tbl[1] = '{1, 32767, 32700, 0, 32256, 32767, 0};
    tbl[2] = '{2, 4096, 0, 0, 4112, 27, 0};
    tbl[3] = '{3, 0, 0, 1000, 8, 11, 1};
    tbl[4] = '{4, 0, 0, 100, 0, 11, 0};
    tbl[5] = '{5, -32768, -32768, -32768, -32768, -32768, 0};
    tbl[6] = '{6, 3, 0, 1000, 11, 11, 1};
    tbl[7] = '{7, 4, 0, 1000, 12, 11, 0};

    rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0;
    cfg_i = '0; cfg_v = '0; cfg_w = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_spike", spike, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_v", out_v, 0);
    chk("rst_w", out_w, 0);
    rst = 1'b0;
    @(negedge clk);

    // Step from reset state.
    model_reset();
    model_expect();
    run_step(1'b0);
    idle_check();

    // Table vectors: i written first, then v/w, so v/w writes must keep i.
    for (int t = 0; t < N; t++) begin
      cfg_write(tbl[t].idx, 1'b0, 0, 0, tbl[t].i);
      cfg_write(tbl[t].idx, 1'b1, tbl[t].v, tbl[t].w, 0);
      mv[tbl[t].idx] = tbl[t].v;
      mw[tbl[t].idx] = tbl[t].w;
      mi[tbl[t].idx] = tbl[t].i;
      ev[tbl[t].idx] = tbl[t].exp_v;
      ew[tbl[t].idx] = tbl[t].exp_w;
      es[tbl[t].idx] = tbl[t].exp_spike;
    end
    run_step(1'b0);

    // Back-to-back: start raised in the done cycle.
    model_expect();
    run_step(1'b0);
    idle_check();

    // start and cfg_we while busy must be ignored.
    model_expect();
    run_step(1'b1);
    idle_check();
    idle_check();
    model_expect();
    run_step(1'b0);
    idle_check();

    // Reset mid-step abandons the step and restores the state arrays.
    start = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= N + 8; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 5) rst = 1'b1;
      if (n == 6) begin
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_spike", spike, 0);
        chk("midrst_idx", out_idx, 0);
        chk("midrst_v", out_v, 0);
        chk("midrst_w", out_w, 0);
        rst = 1'b0;
      end else if (n > 6) begin
        chk("abandon_done", done, 0);
        chk("abandon_valid", out_valid, 0);
        chk("abandon_busy", busy, 0);
      end
    end
    model_reset();
    model_expect();
    run_step(1'b0);
    idle_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
